// File: rtl/alu_issue_stage_if.sv
// Issue/result handshake bundle for alu_issue_stage.
// The decoder side (in_*) offers decoded ALU instructions; the MEM/WB side
// (out_*) consumes results. The stage itself connects through the slave modport.
interface alu_issue_stage_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_funct3;
  logic              in_funct7_5;
  logic              in_is_imm;
  logic [1:0]        in_a_sel;
  logic [REG_AW-1:0] in_rs1;
  logic [REG_AW-1:0] in_rs2;
  logic [XLEN-1:0]   in_rs1_val;
  logic [XLEN-1:0]   in_rs2_val;
  logic [XLEN-1:0]   in_imm;
  logic [XLEN-1:0]   in_pc;
  logic [REG_AW-1:0] in_rd;

  logic              out_valid;
  logic              out_ready;
  logic [REG_AW-1:0] out_rd;
  logic [XLEN-1:0]   out_data;

  modport master (
    output in_valid, in_funct3, in_funct7_5, in_is_imm, in_a_sel,
           in_rs1, in_rs2, in_rs1_val, in_rs2_val, in_imm, in_pc, in_rd,
    input  in_ready,
    input  out_valid, out_rd, out_data,
    output out_ready
  );

  modport slave (
    input  in_valid, in_funct3, in_funct7_5, in_is_imm, in_a_sel,
           in_rs1, in_rs2, in_rs1_val, in_rs2_val, in_imm, in_pc, in_rd,
    output in_ready,
    output out_valid, out_rd, out_data,
    input  out_ready
  );
endinterface

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID/EX stage in front of the ALU.
// S1 (issue register) holds the encoded func and selected operands and drives
// the ALU directly; S2 (result register) captures the ALU result for MEM/WB.
// Optional feature macro: ALU_ISSUE_FORWARD_EN enables a writeback bypass into
// the operands at accept time and while S1 is stalled. Without it the wb_*
// ports are present but ignored.
module alu_issue_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  alu_issue_stage_if.slave  bus,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic [3:0]        alu_func,
  output logic [XLEN-1:0]   alu_in1,
  output logic [XLEN-1:0]   alu_in2,
  input  logic [XLEN-1:0]   alu_result
);

  // S1 issue register
  logic              s1_valid_q, s1_valid_d;
  logic [3:0]        s1_func_q,  s1_func_d;
  logic [XLEN-1:0]   s1_op1_q,   s1_op1_d;
  logic [XLEN-1:0]   s1_op2_q,   s1_op2_d;
  logic [REG_AW-1:0] s1_rd_q,    s1_rd_d;
  // S2 result register
  logic              s2_valid_q, s2_valid_d;
  logic [REG_AW-1:0] s2_rd_q,    s2_rd_d;
  logic [XLEN-1:0]   s2_data_q,  s2_data_d;

  logic              s2_adv_s;
  logic              s1_adv_s;
  logic              in_ready_s;
  logic              accept_s;
  logic [3:0]        enc_func_s;
  logic [XLEN-1:0]   rs1_val_s;
  logic [XLEN-1:0]   rs2_val_s;
  logic [XLEN-1:0]   op1_sel_s;
  logic [XLEN-1:0]   op2_sel_s;

`ifdef ALU_ISSUE_FORWARD_EN
  // Source indices and bypass qualifiers kept with the held instruction
  logic [REG_AW-1:0] s1_rs1_q,  s1_rs1_d;
  logic [REG_AW-1:0] s1_rs2_q,  s1_rs2_d;
  logic              s1_fwd1_q, s1_fwd1_d;
  logic              s1_fwd2_q, s1_fwd2_d;

  // A writeback hits a source index only if enabled and not targeting x0
  function automatic logic wb_hit(input logic en, input logic [REG_AW-1:0] wr,
                                  input logic [REG_AW-1:0] idx);
    return en && (wr != {REG_AW{1'b0}}) && (wr == idx);
  endfunction
`else
  logic unused_wb_s;
  assign unused_wb_s = ^{wb_en, wb_rd, wb_data, bus.in_rs1, bus.in_rs2};
`endif

  // Handshake: S1 may advance whenever S2 can take it; no accept during flush
  always_comb begin
    s2_adv_s   = !s2_valid_q || bus.out_ready;
    s1_adv_s   = s2_adv_s;
    in_ready_s = !flush && (!s1_valid_q || s1_adv_s);
    accept_s   = bus.in_valid && in_ready_s;
  end

  // Decode the incoming instruction: ALU func encoding and operand selection
  always_comb begin
    enc_func_s = {1'b0, bus.in_funct3};
    if ((bus.in_funct3 == 3'b101) || ((bus.in_funct3 == 3'b000) && !bus.in_is_imm)) begin
      enc_func_s[3] = bus.in_funct7_5;
    end else begin
      enc_func_s[3] = 1'b0;
    end
    rs1_val_s = bus.in_rs1_val;
    rs2_val_s = bus.in_rs2_val;
`ifdef ALU_ISSUE_FORWARD_EN
    if ((bus.in_a_sel == 2'b00) && wb_hit(wb_en, wb_rd, bus.in_rs1)) begin
      rs1_val_s = wb_data;
    end else begin
      rs1_val_s = bus.in_rs1_val;
    end
    if (!bus.in_is_imm && wb_hit(wb_en, wb_rd, bus.in_rs2)) begin
      rs2_val_s = wb_data;
    end else begin
      rs2_val_s = bus.in_rs2_val;
    end
`endif
    case (bus.in_a_sel)
      2'b00:   op1_sel_s = rs1_val_s;
      2'b01:   op1_sel_s = bus.in_pc;
      default: op1_sel_s = {XLEN{1'b0}};
    endcase
    if (bus.in_is_imm) begin
      op2_sel_s = bus.in_imm;
    end else begin
      op2_sel_s = rs2_val_s;
    end
  end

  // S1 next state: flush kills, accept loads, advance empties, stall holds
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_func_d  = s1_func_q;
    s1_op1_d   = s1_op1_q;
    s1_op2_d   = s1_op2_q;
    s1_rd_d    = s1_rd_q;
`ifdef ALU_ISSUE_FORWARD_EN
    s1_rs1_d   = s1_rs1_q;
    s1_rs2_d   = s1_rs2_q;
    s1_fwd1_d  = s1_fwd1_q;
    s1_fwd2_d  = s1_fwd2_q;
`endif
    if (flush) begin
      s1_valid_d = 1'b0;
    end else if (accept_s) begin
      s1_valid_d = 1'b1;
      s1_func_d  = enc_func_s;
      s1_op1_d   = op1_sel_s;
      s1_op2_d   = op2_sel_s;
      s1_rd_d    = bus.in_rd;
`ifdef ALU_ISSUE_FORWARD_EN
      s1_rs1_d   = bus.in_rs1;
      s1_rs2_d   = bus.in_rs2;
      s1_fwd1_d  = (bus.in_a_sel == 2'b00);
      s1_fwd2_d  = !bus.in_is_imm;
`endif
    end else if (s1_adv_s) begin
      s1_valid_d = 1'b0;
    end else begin
`ifdef ALU_ISSUE_FORWARD_EN
      // Stalled: keep the held operands current with the register file
      if (s1_valid_q && s1_fwd1_q && wb_hit(wb_en, wb_rd, s1_rs1_q)) begin
        s1_op1_d = wb_data;
      end else begin
        s1_op1_d = s1_op1_q;
      end
      if (s1_valid_q && s1_fwd2_q && wb_hit(wb_en, wb_rd, s1_rs2_q)) begin
        s1_op2_d = wb_data;
      end else begin
        s1_op2_d = s1_op2_q;
      end
`else
      s1_valid_d = s1_valid_q;
`endif
    end
  end

  // S2 next state: capture ALU result when S1 moves, drain on consumer handshake
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_rd_d    = s2_rd_q;
    s2_data_d  = s2_data_q;
    if (flush) begin
      s2_valid_d = 1'b0;
    end else if (s1_adv_s && s1_valid_q) begin
      s2_valid_d = 1'b1;
      s2_rd_d    = s1_rd_q;
      s2_data_d  = alu_result;
    end else if (s2_valid_q && bus.out_ready) begin
      s2_valid_d = 1'b0;
    end else begin
      s2_valid_d = s2_valid_q;
    end
  end

  // Pipeline registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_func_q  <= 4'b0000;
      s1_op1_q   <= {XLEN{1'b0}};
      s1_op2_q   <= {XLEN{1'b0}};
      s1_rd_q    <= {REG_AW{1'b0}};
      s2_valid_q <= 1'b0;
      s2_rd_q    <= {REG_AW{1'b0}};
      s2_data_q  <= {XLEN{1'b0}};
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_func_q  <= s1_func_d;
      s1_op1_q   <= s1_op1_d;
      s1_op2_q   <= s1_op2_d;
      s1_rd_q    <= s1_rd_d;
      s2_valid_q <= s2_valid_d;
      s2_rd_q    <= s2_rd_d;
      s2_data_q  <= s2_data_d;
    end
  end

`ifdef ALU_ISSUE_FORWARD_EN
  // Bypass bookkeeping registers for the held instruction
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_rs1_q  <= {REG_AW{1'b0}};
      s1_rs2_q  <= {REG_AW{1'b0}};
      s1_fwd1_q <= 1'b0;
      s1_fwd2_q <= 1'b0;
    end else begin
      s1_rs1_q  <= s1_rs1_d;
      s1_rs2_q  <= s1_rs2_d;
      s1_fwd1_q <= s1_fwd1_d;
      s1_fwd2_q <= s1_fwd2_d;
    end
  end
`endif

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = s2_valid_q;
  assign bus.out_rd    = s2_rd_q;
  assign bus.out_data  = s2_data_q;
  assign alu_func      = s1_func_q;
  assign alu_in1       = s1_op1_q;
  assign alu_in2       = s1_op2_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: a behavioural ALU drives alu_result, a queue-based
// model of in-flight instructions predicts every output, and a few literal
// expectations pin the model on known instructions.
module tb_alu_issue_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [3:0]  alu_func;
  logic [31:0] alu_in1, alu_in2, alu_result;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  alu_issue_stage_if #(.XLEN(32), .REG_AW(5)) iif ();

  alu_issue_stage #(.XLEN(32), .REG_AW(5)) dut (
    .clock(clock), .reset(reset), .flush(flush), .bus(iif),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .alu_func(alu_func), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_result(alu_result)
  );

  always #5 clock = ~clock;

  // RV32I ALU semantics
  function automatic logic [31:0] alu_ref(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      4'b0000: return a + b;
      4'b1000: return a - b;
      4'b0001: return a << b[4:0];
      4'b0010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0011: return (a < b) ? 32'd1 : 32'd0;
      4'b0100: return a ^ b;
      4'b0101: return a >> b[4:0];
      4'b1101: return $unsigned($signed(a) >>> b[4:0]);
      4'b0110: return a | b;
      4'b0111: return a & b;
      default: return a + b;
    endcase
  endfunction

  always_comb alu_result = alu_ref(alu_func, alu_in1, alu_in2);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [3:0]  func;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [1:0]  asel;
    logic        is_imm;
    logic        fresh;   // accepted on the most recent edge (still in S1)
  } ent_t;

  ent_t q[$];

  function automatic logic wb_match(input logic [4:0] idx);
    return wb_en && (wb_rd != 5'd0) && (wb_rd == idx);
  endfunction

  function automatic ent_t mk_ent();
    ent_t e;
    logic [31:0] r1, r2;
    logic alt;
    r1 = iif.in_rs1_val;
    r2 = iif.in_rs2_val;
`ifdef ALU_ISSUE_FORWARD_EN
    if (wb_match(iif.in_rs1)) r1 = wb_data;
    if (wb_match(iif.in_rs2)) r2 = wb_data;
`endif
    alt = (iif.in_funct3 == 3'd5) || (iif.in_funct3 == 3'd0 && !iif.in_is_imm);
    e.func   = {alt ? iif.in_funct7_5 : 1'b0, iif.in_funct3};
    e.op1    = (iif.in_a_sel == 2'd0) ? r1 : (iif.in_a_sel == 2'd1) ? iif.in_pc : 32'd0;
    e.op2    = iif.in_is_imm ? iif.in_imm : r2;
    e.rd     = iif.in_rd;
    e.rs1    = iif.in_rs1;
    e.rs2    = iif.in_rs2;
    e.asel   = iif.in_a_sel;
    e.is_imm = iif.in_is_imm;
    e.fresh  = 1'b1;
    return e;
  endfunction

  function automatic logic m_out_valid();
    return (q.size() == 2) || (q.size() == 1 && !q[0].fresh);
  endfunction

  function automatic logic m_s1_full();
    return (q.size() == 2) || (q.size() == 1 && q[0].fresh);
  endfunction

  function automatic logic m_in_ready();
    return !flush && (q.size() < 2 || iif.out_ready);
  endfunction

  // Model update on each active edge, from the inputs the DUT samples
  always @(posedge clock) begin
    logic ov, rdy;
    ent_t e;
    ov  = m_out_valid();
    rdy = m_in_ready();
    if (reset || flush) begin
      q.delete();
    end else begin
`ifdef ALU_ISSUE_FORWARD_EN
      if (q.size() == 2 && !iif.out_ready) begin
        e = q[1];
        if (e.asel == 2'd0 && wb_match(e.rs1)) e.op1 = wb_data;
        if (!e.is_imm && wb_match(e.rs2)) e.op2 = wb_data;
        q[1] = e;
      end
`endif
      if (ov && iif.out_ready) void'(q.pop_front());
      foreach (q[i]) begin
        e = q[i];
        e.fresh = 1'b0;
        q[i] = e;
      end
      if (iif.in_valid && rdy) q.push_back(mk_ent());
    end
  end

  // Compare DUT against the model every cycle, away from the active edge
  always @(negedge clock) begin
    ent_t h, s;
    if (cmp_en) begin
      chk("in_ready", {31'd0, iif.in_ready}, {31'd0, m_in_ready()});
      chk("out_valid", {31'd0, iif.out_valid}, {31'd0, m_out_valid()});
      if (m_out_valid()) begin
        h = q[0];
        chk("out_rd", {27'd0, iif.out_rd}, {27'd0, h.rd});
        chk("out_data", iif.out_data, alu_ref(h.func, h.op1, h.op2));
      end
      if (m_s1_full()) begin
        s = q[q.size()-1];
        chk("alu_func", {28'd0, alu_func}, {28'd0, s.func});
        chk("alu_in1", alu_in1, s.op1);
        chk("alu_in2", alu_in2, s.op2);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [2:0] f3, input logic f7, input logic imm_sel, input logic [1:0] asel,
                       input logic [4:0] rs1, input logic [31:0] r1v, input logic [31:0] r2v,
                       input logic [31:0] imm, input logic [31:0] pc, input logic [4:0] rd);
    iif.in_valid    = 1'b1;
    iif.in_funct3   = f3;
    iif.in_funct7_5 = f7;
    iif.in_is_imm   = imm_sel;
    iif.in_a_sel    = asel;
    iif.in_rs1      = rs1;
    iif.in_rs2      = 5'd2;
    iif.in_rs1_val  = r1v;
    iif.in_rs2_val  = r2v;
    iif.in_imm      = imm;
    iif.in_pc       = pc;
    iif.in_rd       = rd;
  endtask

  logic [31:0] seen[$];
  logic [31:0] a_data;
  logic [31:0] exp_bp[3];
  bit          acc;

  initial begin
    reset = 1'b1; flush = 1'b0; wb_en = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
    drive(3'd0, 1'b0, 1'b0, 2'd0, 5'd1, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0);
    iif.in_valid  = 1'b0;
    iif.out_ready = 1'b1;

    // reset state
    repeat (2) @(negedge clock);
    chk("rst_out_valid", {31'd0, iif.out_valid}, 32'd0);
    chk("rst_alu_func", {28'd0, alu_func}, 32'd0);
    chk("rst_alu_in1", alu_in1, 32'd0);
    chk("rst_alu_in2", alu_in2, 32'd0);
    chk("rst_out_data", iif.out_data, 32'd0);
    chk("rst_in_ready", {31'd0, iif.in_ready}, 32'd1);
    cmp_en = 1'b1;

    // SUB, SRAI, ADDI(f7=1), AUIPC, LUI back to back
    #1 reset = 1'b0;
    drive(3'b000, 1'b1, 1'b0, 2'b00, 5'd1, 32'd10, 32'd3, 32'd0, 32'd0, 5'd3);
    @(negedge clock);
    chk("sub_func", {28'd0, alu_func}, 32'h8);
    #1 drive(3'b101, 1'b1, 1'b1, 2'b00, 5'd1, 32'h8000_0000, 32'd0, 32'd4, 32'd0, 5'd4);
    @(negedge clock);
    chk("sub_data", iif.out_data, 32'd7);
    chk("srai_func", {28'd0, alu_func}, 32'hD);
    #1 drive(3'b000, 1'b1, 1'b1, 2'b00, 5'd1, 32'd5, 32'd0, 32'd6, 32'd0, 5'd5);
    @(negedge clock);
    chk("srai_data", iif.out_data, 32'hF800_0000);
    chk("addi_func", {28'd0, alu_func}, 32'h0);
    #1 drive(3'b000, 1'b0, 1'b1, 2'b01, 5'd1, 32'd77, 32'd0, 32'h2000, 32'h100, 5'd6);
    @(negedge clock);
    chk("addi_data", iif.out_data, 32'd11);
    #1 drive(3'b000, 1'b0, 1'b1, 2'b10, 5'd1, 32'd77, 32'd0, 32'h1234_5000, 32'h100, 5'd7);
    @(negedge clock);
    chk("auipc_data", iif.out_data, 32'h2100);
    #1 iif.in_valid = 1'b0;
    @(negedge clock);
    chk("lui_data", iif.out_data, 32'h1234_5000);
    @(negedge clock);

    // backpressure: out_ready low for three edges with three offered inputs
    exp_bp[0] = 32'd2; exp_bp[1] = 32'd3; exp_bp[2] = 32'd4;
    #1 iif.out_ready = 1'b0;
    drive(3'b000, 1'b0, 1'b1, 2'b00, 5'd1, 32'd1, 32'd0, 32'd1, 32'd0, 5'd8);
    @(negedge clock);
    #1 drive(3'b000, 1'b0, 1'b1, 2'b00, 5'd1, 32'd1, 32'd0, 32'd2, 32'd0, 5'd9);
    @(negedge clock);
    #1 drive(3'b000, 1'b0, 1'b1, 2'b00, 5'd1, 32'd1, 32'd0, 32'd3, 32'd0, 5'd10);
    @(negedge clock);
    chk("bp_in_ready", {31'd0, iif.in_ready}, 32'd0);
    chk("bp_out_valid", {31'd0, iif.out_valid}, 32'd1);
    a_data = iif.out_data;
    seen.push_back(a_data);
    #1 iif.out_ready = 1'b1;
    #1 acc = iif.in_valid && iif.in_ready;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      if (iif.out_valid) seen.push_back(iif.out_data);
      #1 if (acc) iif.in_valid = 1'b0;
      #1 acc = iif.in_valid && iif.in_ready;
    end
    iif.in_valid = 1'b0;
    chk("bp_count", seen.size(), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk("bp_order", (i < seen.size()) ? seen[i] : 32'hDEAD_BEEF, exp_bp[i]);
    end

    // flush with S1 and S2 both full
    @(negedge clock);
    #1 iif.out_ready = 1'b0;
    drive(3'b100, 1'b0, 1'b0, 2'b00, 5'd1, 32'hF0F0_0000, 32'h0FF0_0000, 32'd0, 32'd0, 5'd11);
    @(negedge clock);
    #1 drive(3'b110, 1'b0, 1'b1, 2'b00, 5'd1, 32'h1, 32'd0, 32'h10, 32'd0, 5'd12);
    @(negedge clock);
    chk("fl_pre_valid", {31'd0, iif.out_valid}, 32'd1);
    #1 flush = 1'b1;
    drive(3'b111, 1'b0, 1'b1, 2'b00, 5'd1, 32'hFF, 32'd0, 32'h0F, 32'd0, 5'd13);
    #1 chk("fl_in_ready", {31'd0, iif.in_ready}, 32'd0);
    @(negedge clock);
    chk("fl_out_valid", {31'd0, iif.out_valid}, 32'd0);
    #1 flush = 1'b0; iif.in_valid = 1'b0; iif.out_ready = 1'b1;
    @(negedge clock);
    chk("fl_empty", {31'd0, iif.out_valid}, 32'd0);

`ifdef ALU_ISSUE_FORWARD_EN
    // writeback bypass at accept, and no bypass for x0
    #1 drive(3'b000, 1'b0, 1'b1, 2'b00, 5'd5, 32'd1, 32'd0, 32'd0, 32'd0, 5'd14);
    wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'd9;
    @(negedge clock);
    chk("fwd_in1", alu_in1, 32'd9);
    #1 drive(3'b000, 1'b0, 1'b1, 2'b00, 5'd0, 32'd1, 32'd0, 32'd0, 32'd0, 5'd15);
    wb_rd = 5'd0;
    @(negedge clock);
    chk("fwd_x0_in1", alu_in1, 32'd1);
    #1 iif.in_valid = 1'b0; wb_en = 1'b0;
    @(negedge clock);
`endif

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      #1;
      iif.in_valid    = ($urandom_range(0, 3) != 0);
      iif.in_funct3   = 3'($urandom_range(0, 7));
      iif.in_funct7_5 = 1'($urandom_range(0, 1));
      iif.in_is_imm   = 1'($urandom_range(0, 1));
      iif.in_a_sel    = 2'($urandom_range(0, 3));
      iif.in_rs1      = 5'($urandom_range(0, 7));
      iif.in_rs2      = 5'($urandom_range(0, 7));
      iif.in_rs1_val  = $urandom;
      iif.in_rs2_val  = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40));
      iif.in_imm      = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 31));
      iif.in_pc       = $urandom;
      iif.in_rd       = 5'($urandom_range(0, 31));
      iif.out_ready   = ($urandom_range(0, 9) < 6);
      flush           = ($urandom_range(0, 49) == 0);
      wb_en           = 1'($urandom_range(0, 1));
      wb_rd           = 5'($urandom_range(0, 7));
      wb_data         = $urandom;
    end

    // drain
    @(negedge clock);
    #1 iif.in_valid = 1'b0; flush = 1'b0; iif.out_ready = 1'b1; wb_en = 1'b0;
    repeat (4) @(negedge clock);
    chk("drain_empty", {31'd0, iif.out_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
